// File: rtl/shift_register_piso_param.sv
// Parallel-in serial-out shifter; first bit is presented the cycle after load, no extra latency.
// Backpressure: shift=0 stalls the word in place; load_ready is high only in IDLE or while the last bit is being taken.
module shift_register_piso_param #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift,
    output logic             q_out,
    output logic             q_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             at_last;
    logic             load_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        at_last    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        load_ready = (state_q == IDLE) || (at_last && shift);
        load_acc   = load_valid && load_ready;

        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    state_d = SHIFT;
                    sreg_d  = data;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (shift) begin
                    if (cnt_q == CNT_LAST) begin
                        // Back-to-back load reuses the final bit cycle, so no idle bubble.
                        if (load_acc) begin
                            sreg_d = data;
                        end else begin
                            state_d = IDLE;
                            sreg_d  = '0;
                        end
                        cnt_d = '0;
                    end else begin
                        sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg_q[WIDTH-1:1]};
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == SHIFT);
        q_valid = busy;
        q_out   = busy && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
        last    = at_last;
    end

endmodule
